// File: rtl/anton_neopixel_pixel_fetch.sv
// anton_neopixel_pixel_fetch: double-buffered pixel fetch and NeoPixel bit serialiser with underrun detection
module anton_neopixel_pixel_fetch #(
  parameter int BUFFER_END = 255,
  parameter int T0H_STEPS = 2,
  parameter int T1H_STEPS = 5,
  localparam int BUFFER_BITS = $clog2(BUFFER_END + 1)
) (
  input  logic                   clk7mhz,
  input  logic                   rst,
  input  logic                   reg_ctrl_init,
  input  logic                   reg_ctrl_32bit,
  input  logic [BUFFER_BITS-1:0] pixel_index_max,
  input  logic                   stream_output,
  input  logic                   stream_bit_of,
  input  logic                   stream_pixel_of,
  input  logic [4:0]             pixel_bit_index,
  input  logic [2:0]             bit_pattern_index,
  output logic                   rd_req,
  output logic [BUFFER_BITS-1:0] rd_addr,
  input  logic                   rd_ack,
  input  logic [23:0]            rd_data,
  output logic                   neo_data,
  output logic                   underrun
);
  typedef enum logic [1:0] {F_IDLE, F_REQ, F_FULL} state_t;
  state_t state, state_nx;
  logic [23:0] active, shadow;
  logic active_valid, shadow_valid, ack, preload, consume, bit_val;
  logic [BUFFER_BITS-1:0] fetch_addr, equiv, addr_nx;
  assign rd_req = state == F_REQ;
  assign rd_addr = fetch_addr;
  assign ack = rd_req && rd_ack;
  assign preload = !stream_bit_of && !stream_output && !active_valid && shadow_valid;
  assign consume = preload || (stream_bit_of && !stream_pixel_of && shadow_valid);
  assign bit_val = active[5'd23 - pixel_bit_index];
  // in 32-bit mode a pixel occupies a 4-address slot; wrap on its last address
  assign equiv = reg_ctrl_32bit ? {fetch_addr[BUFFER_BITS-1:2], 2'b11} : fetch_addr;
  assign addr_nx = equiv == pixel_index_max ? '0
                 : fetch_addr + (reg_ctrl_32bit ? BUFFER_BITS'(4) : BUFFER_BITS'(1));
  always_comb begin
    state_nx = state;
    state_nx = state == F_IDLE ? (shadow_valid ? F_IDLE : F_REQ)
             : state == F_REQ  ? (rd_ack ? F_FULL : F_REQ)
             : (shadow_valid ? F_FULL : F_IDLE);
  end
  always_ff @(posedge clk7mhz or posedge rst) begin
    if (rst) begin
      state <= F_IDLE;
      active <= '0;
      shadow <= '0;
      active_valid <= 1'b0;
      shadow_valid <= 1'b0;
      fetch_addr <= '0;
      neo_data <= 1'b0;
      underrun <= 1'b0;
    end else if (reg_ctrl_init) begin
      state <= F_IDLE;
      active <= '0;
      shadow <= '0;
      active_valid <= 1'b0;
      shadow_valid <= 1'b0;
      fetch_addr <= '0;
      neo_data <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state <= state_nx;
      neo_data <= stream_output && active_valid
                  && (int'(bit_pattern_index) < (bit_val ? T1H_STEPS : T0H_STEPS));
      if (ack) begin
        shadow <= rd_data;
        fetch_addr <= addr_nx;
      end
      // a fresh ack refills the shadow even when the old contents are consumed this cycle
      shadow_valid <= ack || (shadow_valid && !consume);
      if (stream_bit_of) begin
        if (stream_pixel_of) active_valid <= 1'b0;
        else if (shadow_valid) active <= shadow;
        else begin
          underrun <= 1'b1;
          active <= '0;
        end
      end else if (preload) begin
        active <= shadow;
        active_valid <= 1'b1;
      end
    end
  end
endmodule
